// File: rtl/pipe_wb.sv
// Write-back stage: result select, 32x32 register file with two async read ports, commit counter.
// Optional WB_BYPASS_EN: write-through bypass of the committing value onto the read ports.
module pipe_wb #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             WBwreg,
  input  logic             WBm2reg,
  input  logic [4:0]       WBwn,
  input  logic [31:0]      WBaluResult,
  input  logic [31:0]      WBmemOut,
  input  logic [4:0]       IDrn1,
  input  logic [4:0]       IDrn2,
  output logic [31:0]      IDqa,
  output logic [31:0]      IDqb,
  output logic [31:0]      WBresult,
  output logic             WBcommit,
  output logic [CNT_W-1:0] wbCount
);

  // Register 0 has no storage; it is synthesised as a constant zero on the read side.
  logic [31:0]      rf [1:31];
  logic [CNT_W-1:0] count_reg;

  assign WBresult = WBm2reg ? WBmemOut : WBaluResult;
  assign WBcommit = WBwreg & (WBwn != 5'd0);
  assign wbCount  = count_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 1; i < 32; i++) begin
        rf[i] <= '0;
      end
    end else if (WBcommit) begin
      rf[WBwn] <= WBresult;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_reg <= '0;
    end else if (WBcommit) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [4:0]  rn;
      logic [31:0] q;

      assign rn = (gi == 0) ? IDrn1 : IDrn2;

      always_comb begin
        q = '0;
        if (rn != 5'd0) begin
          q = rf[rn];
        end
`ifdef WB_BYPASS_EN
        // Bypass is suppressed in reset so the ports read 0 while clrn is low.
        if (clrn && WBcommit && (rn == WBwn)) begin
          q = WBresult;
        end
`endif
      end
    end
  endgenerate

  assign IDqa = g_rd[0].q;
  assign IDqb = g_rd[1].q;

endmodule

// File: tb/tb_pipe_wb.sv
// Directed self-checking bench for pipe_wb; a second instance with CNT_W=4 checks counter wrap.
module tb_pipe_wb;

  logic        clk = 1'b0;
  logic        clrn;
  logic        WBwreg;
  logic        WBm2reg;
  logic [4:0]  WBwn;
  logic [31:0] WBaluResult;
  logic [31:0] WBmemOut;
  logic [4:0]  IDrn1;
  logic [4:0]  IDrn2;
  logic [31:0] IDqa, IDqb, WBresult;
  logic        WBcommit;
  logic [31:0] wbCount;
  logic [31:0] IDqa4, IDqb4, WBresult4;
  logic        WBcommit4;
  logic [3:0]  wbCount4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_wb dut (
    .clk(clk), .clrn(clrn), .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
    .WBaluResult(WBaluResult), .WBmemOut(WBmemOut), .IDrn1(IDrn1), .IDrn2(IDrn2),
    .IDqa(IDqa), .IDqb(IDqb), .WBresult(WBresult), .WBcommit(WBcommit), .wbCount(wbCount)
  );

  pipe_wb #(.CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
    .WBaluResult(WBaluResult), .WBmemOut(WBmemOut), .IDrn1(IDrn1), .IDrn2(IDrn2),
    .IDqa(IDqa4), .IDqb(IDqb4), .WBresult(WBresult4), .WBcommit(WBcommit4), .wbCount(wbCount4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wreg, input logic m2reg, input logic [4:0] wn,
                       input logic [31:0] alu, input logic [31:0] mem);
    WBwreg = wreg; WBm2reg = m2reg; WBwn = wn; WBaluResult = alu; WBmemOut = mem;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    idle();
    IDrn1 = 5'd0; IDrn2 = 5'd0;
    clrn = 1'b0;
    tick(); tick();
    #3 clrn = 1'b1;
    tick();
    for (int a = 0; a < 32; a++) begin
      IDrn1 = 5'(a); IDrn2 = 5'(31 - a);
      #1;
      checks++;
      if (IDqa !== 32'h0 || IDqb !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d qa=%h qb=%h required 0", a, IDqa, IDqb);
      end
    end
    checks++;
    if (wbCount !== 32'd0 || wbCount4 !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d/%0d required 0/0", wbCount, wbCount4);
    end
    $display("reset: all 32 addresses read, count=%0d", wbCount);
  endtask

  task automatic test_alu_mem();
    drive(1'b1, 1'b0, 5'd5, 32'h12345678, 32'hDEADBEEF);
    #1;
    checks++;
    if (WBresult !== 32'h12345678 || WBcommit !== 1'b1) begin
      errors++;
      $display("FAIL alu_select result=%h commit=%b required 12345678/1", WBresult, WBcommit);
    end
    tick();
    drive(1'b1, 1'b1, 5'd6, 32'h12345678, 32'hDEADBEEF);
    IDrn1 = 5'd5; IDrn2 = 5'd6;
    #1;
    checks++;
    if (IDqa !== 32'h12345678 || wbCount !== 32'd1) begin
      errors++;
      $display("FAIL alu_write qa=%h cnt=%0d required 12345678/1", IDqa, wbCount);
    end
    checks++;
    if (WBresult !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_select result=%h required deadbeef", WBresult);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IDqb !== 32'hDEADBEEF || wbCount !== 32'd2) begin
      errors++;
      $display("FAIL mem_write qb=%h cnt=%0d required deadbeef/2", IDqb, wbCount);
    end
    $display("alu_mem: r5=%h r6=%h count=%0d", IDqa, IDqb, wbCount);
  endtask

  task automatic test_reg0();
    drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    IDrn1 = 5'd0;
    #1;
    checks++;
    if (WBcommit !== 1'b0) begin
      errors++;
      $display("FAIL reg0_commit got %b required 0", WBcommit);
    end
    checks++;
    if (IDqa !== 32'h0) begin
      errors++;
      $display("FAIL reg0_preedge qa=%h required 0", IDqa);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IDqa !== 32'h0 || wbCount !== 32'd2) begin
      errors++;
      $display("FAIL reg0_write qa=%h cnt=%0d required 0/2", IDqa, wbCount);
    end
    $display("reg0: qa=%h count=%0d", IDqa, wbCount);
  endtask

  task automatic test_bypass();
    logic [31:0] exp_pre;
    drive(1'b1, 1'b0, 5'd7, 32'h00000001, 32'h0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'h0, 32'hA5A5A5A5);
    IDrn1 = 5'd7; IDrn2 = 5'd7;
`ifdef WB_BYPASS_EN
    exp_pre = 32'hA5A5A5A5;
`else
    exp_pre = 32'h00000001;
`endif
    #1;
    checks++;
    if (IDqa !== exp_pre || IDqb !== exp_pre) begin
      errors++;
      $display("FAIL collision_preedge qa=%h qb=%h required %h", IDqa, IDqb, exp_pre);
    end
    tick();
    idle();
    #1;
    checks++;
    if (IDqa !== 32'hA5A5A5A5 || IDqb !== 32'hA5A5A5A5 || wbCount !== 32'd4) begin
      errors++;
      $display("FAIL collision_postedge qa=%h qb=%h cnt=%0d required a5a5a5a5/4", IDqa, IDqb, wbCount);
    end
    $display("bypass: pre=%h post=%h count=%0d", exp_pre, IDqa, wbCount);
  endtask

  task automatic test_wrap();
    idle();
    #2 clrn = 1'b0;
    #2 clrn = 1'b1;
    tick();
    checks++;
    if (wbCount4 !== 4'd0 || wbCount !== 32'd0) begin
      errors++;
      $display("FAIL wrap_start cnt4=%0d cnt=%0d required 0/0", wbCount4, wbCount);
    end
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 1'b0, 5'd9, 32'(i * 32'h1111), 32'h0);
      tick();
    end
    idle();
    IDrn1 = 5'd9;
    #1;
    checks++;
    if (wbCount4 !== 4'd1 || wbCount !== 32'd17) begin
      errors++;
      $display("FAIL wrap_count cnt4=%0d cnt=%0d required 1/17", wbCount4, wbCount);
    end
    checks++;
    if (IDqa !== 32'h00012221 || IDqa4 !== 32'h00012221) begin
      errors++;
      $display("FAIL last_wins qa=%h qa4=%h required 00012221", IDqa, IDqa4);
    end
    drive(1'b0, 1'bx, 5'bxxxxx, 32'hBADBAD00, 32'hBADBAD11);
    tick();
    drive(1'b0, 1'b0, 5'd9, 32'hBADBAD22, 32'h0);
    tick();
    idle();
    #1;
    checks++;
    if (wbCount4 !== 4'd1 || wbCount !== 32'd17 || IDqa !== 32'h00012221) begin
      errors++;
      $display("FAIL no_wreg cnt4=%0d cnt=%0d qa=%h required 1/17/00012221", wbCount4, wbCount, IDqa);
    end
    $display("wrap: cnt4=%0d cnt=%0d r9=%h", wbCount4, wbCount, IDqa);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 5'd3, 32'h00000055, 32'h0);
    tick();
    idle();
    IDrn1 = 5'd3;
    #1;
    checks++;
    if (IDqa !== 32'h55 || wbCount !== 32'd18) begin
      errors++;
      $display("FAIL pre_reset qa=%h cnt=%0d required 55/18", IDqa, wbCount);
    end
    drive(1'b1, 1'b0, 5'd3, 32'h00000077, 32'h0);
    #1 clrn = 1'b0;
    #1;
    checks++;
    if (IDqa !== 32'h0 || wbCount !== 32'd0 || wbCount4 !== 4'd0) begin
      errors++;
      $display("FAIL async_clear qa=%h cnt=%0d cnt4=%0d required 0", IDqa, wbCount, wbCount4);
    end
    checks++;
    if (WBresult !== 32'h77 || WBcommit !== 1'b1) begin
      errors++;
      $display("FAIL reset_comb result=%h commit=%b required 77/1", WBresult, WBcommit);
    end
    tick();
    checks++;
    if (IDqa !== 32'h0 || wbCount !== 32'd0) begin
      errors++;
      $display("FAIL reset_write_lost qa=%h cnt=%0d required 0/0", IDqa, wbCount);
    end
    idle();
    #2 clrn = 1'b1;
    #1;
    checks++;
    if (IDqa !== 32'h0 || wbCount !== 32'd0) begin
      errors++;
      $display("FAIL post_release qa=%h cnt=%0d required 0/0", IDqa, wbCount);
    end
    $display("async_reset: qa=%h count=%0d", IDqa, wbCount);
  endtask

  initial begin
    test_reset();
    test_alu_mem();
    test_reg0();
    test_bypass();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_wb.md
# pipe_WB

Write-back stage of the five-stage pipeline. It consumes the MEM/WB register outputs and selects the write-back result: the ALU result, or the load data when the instruction is a load. It commits that result into the 32×32 general-purpose register file, which it owns, and serves the two combinational read ports used by the ID stage. It also keeps a wrapping count of committed register writes for performance monitoring.

## Interface
Parameters:
- CNT_W, default 32: width of the committed-write counter.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- clrn  input  1  asynchronous active-low reset
- WBwreg  input  1  instruction in WB writes a register
- WBm2reg  input  1  1 = result comes from WBmemOut, 0 = from WBaluResult
- WBwn  input  5  destination register number
- WBaluResult  input  32  ALU result carried from MEM
- WBmemOut  input  32  data-memory read data carried from MEM
- IDrn1  input  5  ID read address A (rs)
- IDrn2  input  5  ID read address B (rt)
- IDqa  output  32  register value for IDrn1
- IDqb  output  32  register value for IDrn2
- WBresult  output  32  selected write-back value, for the forwarding mux
- WBcommit  output  1  this cycle's write is architecturally effective
- wbCount  output  CNT_W  number of effective writes since reset

## Operation
- WBresult = WBm2reg ? WBmemOut : WBaluResult. Purely combinational; valid every cycle, even when WBwreg=0.
- WBcommit = WBwreg & (WBwn != 0). Combinational.
- Register file: 32 entries of 32 bits.
  - Register 0 is hardwired to 0. Writes to it are discarded, and reads of it always return 0.
  - On a rising edge of clk with WBcommit=1, regfile[WBwn] <= WBresult.
- Read ports are combinational and asynchronous:
  - IDqa = regfile[IDrn1].
  - IDqb = regfile[IDrn2].
  - For the same-cycle read/write collision rule, see Configuration.
- Counter: on a rising edge of clk with WBcommit=1, wbCount <= wbCount + 1, modulo 2^CNT_W. It wraps from all-ones to 0 silently, with no flag.
- No stall or flush inputs. Bubbles arrive as WBwreg=0, and the MEM/WB register is responsible for clearing them.

## Timing
- Reset (clrn=0): asynchronously clears all registers 1–31 to 0 and wbCount to 0.
  - While clrn=0, IDqa and IDqb read 0.
  - WBresult and WBcommit still follow their inputs combinationally.
- Reset asserted mid-operation: any write pending for that edge is lost.
- Release of clrn is synchronised externally; the first write can happen on the first rising edge after release.
- Write latency: 1 edge. The value is visible on the read ports after the commit edge.
- IDrn1 == IDrn2: both ports return the same value.
- Two consecutive writes to the same register: the last one wins, and wbCount increments twice.
- X on WBwn or WBm2reg while WBwreg=0 must not corrupt state.

## Configuration
- Macro: WB_BYPASS_EN.
- Defined: write-through bypass is enabled.
  - If WBcommit=1 and IDrn1 == WBwn, IDqa = WBresult in the same cycle, before the edge. IDqb behaves the same way for IDrn2.
  - This removes the WB→ID hazard, giving the ID stage the half-cycle read-after-write behaviour that a negedge-written file would.
- Undefined: no bypass. Reads return the pre-edge stored value, and the forwarding unit must cover the WB→ID distance.
- Register 0 reads 0 in both builds.

## Test plan
- Reset, then read all 32 addresses on both ports → all 0; wbCount = 0.
- Commit WBwreg=1, WBm2reg=0, WBwn=5, WBaluResult=0x12345678 with WBmemOut=0xDEADBEEF → after the edge, IDrn1=5 gives IDqa=0x12345678 and wbCount=1. Repeat with WBm2reg=1, WBwn=6 → IDqb=0xDEADBEEF and wbCount=2.
- Write 0xFFFFFFFF to WBwn=0 → IDqa(0)=0, WBcommit=0, wbCount unchanged.
- Same cycle: write 0xA5A5A5A5 to register 7 and read IDrn1=7 while it currently holds 0x1 → IDqa = 0xA5A5A5A5 before the edge with WB_BYPASS_EN defined, 0x1 without; 0xA5A5A5A5 after the edge in both builds.
- Build with CNT_W=4 and perform 17 commits → wbCount = 1 (wrapped). A commit issued with WBwreg=0 leaves the count and the register unchanged.
- Write 0x55 to register 3, then assert clrn low between edges → IDqa(3)=0 and wbCount=0 immediately, with no clock edge. The write presented on the next edge while clrn=0 is discarded.
